imem_boot_controller: RTL and testbench

Sequences the word-addressed instruction memory (256 x 32-bit by default) through a boot process:
- zero-fill the memory,
- stream a program image into it over a valid/ready interface,
- release the CPU to fetch.

Owns the instruction-memory write port exclusively. Holds the single-cycle core stalled until the image is resident.

---
 rtl/imem_boot_controller_pkg.sv | 18 +
 rtl/imem_addr_counter.sv | 36 +++
 rtl/imem_boot_controller.sv | 159 +++++++++++++++
 tb/tb_imem_boot_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_controller_pkg.sv
// Shared definitions for the instruction-memory boot controller:
// the boot state encoding, default widths and the zero-fill word.
package imem_boot_controller_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } boot_state_e;

  // Value written to every word during the zero-fill sweep.
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/imem_addr_counter.sv
// Word pointer shared by the zero-fill sweep and the image load.
// Supports clear-to-zero, load-with-base and increment; tc flags the
// last word of the memory so the controller can end a sweep or catch
// an image that would run off the end.
module imem_addr_counter #(
  parameter int ADDR_W    = 8,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load_base,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              tc
);

  // Base address reduced modulo the memory depth.
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(LOAD_BASE);

  // Pointer register; clear wins over load, load wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (load_base) begin
      ptr <= BASE;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

  assign tc = (ptr == {ADDR_W{1'b1}});

endmodule

// File: rtl/imem_boot_controller.sv
// Boot sequencer for the instruction memory: zero-fills every word,
// streams a program image in over a valid/ready port, then releases
// the core. Owns the memory write port and holds the core stalled
// until the image is resident.
// Optional feature macro: IMEM_CHECKSUM_EN adds a running modulo sum
// of the accepted image words; without it checksum is tied to zero.
module imem_boot_controller
  import imem_boot_controller_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_stall,
  output logic              boot_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum
);

  // word_count saturates at the memory depth.
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  boot_state_e       state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_tc;
  logic              ptr_clr, ptr_load, ptr_inc;
  logic              handshake;

  imem_addr_counter #(
    .ADDR_W    (ADDR_W),
    .LOAD_BASE (LOAD_BASE)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .clr       (ptr_clr),
    .load_base (ptr_load),
    .inc       (ptr_inc),
    .ptr       (ptr),
    .tc        (ptr_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and memory/handshake decode; outputs follow the
  // registered state so in_ready never depends on in_valid.
  always_comb begin
    state_nxt = state;
    ptr_clr   = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;
    handshake = 1'b0;
    in_ready  = 1'b0;
    cpu_stall = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = DATA_W'(ZERO_WORD);
    case (state)
      IDLE: begin
        if (start) begin
          ptr_clr   = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (ptr_tc) begin
          ptr_load  = 1'b1;
          state_nxt = LOAD;
        end else begin
          ptr_inc = 1'b1;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        handshake = in_valid;
        if (handshake) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          // At the last word the pointer parks instead of wrapping.
          ptr_inc   = ~ptr_tc;
          if (in_last || ptr_tc) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        cpu_stall = 1'b0;
        if (start) begin
          ptr_clr   = 1'b1;
          state_nxt = CLEAR;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status: boot_done pulse on entry to RUN, sticky overflow and the
  // saturating accepted-word count, all cleared when a boot starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_done  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      boot_done <= (state == LOAD) && (state_nxt == RUN);
      if (ptr_clr) begin
        overflow   <= 1'b0;
        word_count <= '0;
      end else if (handshake) begin
        if (word_count != DEPTH_CNT) begin
          word_count <= word_count + (ADDR_W+1)'(1);
        end
        if (ptr_tc && !in_last) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_acc;

  // Running modulo sum of accepted image words; frozen once in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_acc <= '0;
    end else if (ptr_clr) begin
      checksum_acc <= '0;
    end else if (handshake) begin
      checksum_acc <= checksum_acc + in_data;
    end
  end

  assign checksum = checksum_acc;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_boot_controller.sv
// Self-checking bench for imem_boot_controller on a 16-word memory.
// A reference model built from the boot rules (zero-fill sweep, image
// words at consecutive addresses from the load base, stop on the last
// word or on the final address) predicts every write and status value.
module tb_imem_boot_controller;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 32;
  localparam int LOAD_BASE = 0;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_stall;
  logic              boot_done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] checksum;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] img [$];

  always #5 clk = ~clk;

  imem_boot_controller #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LOAD_BASE (LOAD_BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .boot_done  (boot_done),
    .overflow   (overflow),
    .word_count (word_count),
    .checksum   (checksum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full boot: start pulse, zero-fill sweep, image stream, RUN entry.
  // last_idx < 0 means no word carries in_last. gap_mode: 0 = valid
  // held high, 1 = valid low on alternate cycles, 2 = random gaps.
  task automatic run_boot(input int last_idx, input int gap_mode, input string tag);
    int                k;
    bit                done;
    bit                exp_ovf;
    bit                v;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] exp_ck;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W:0]   prev_wc;
    logic [ADDR_W:0]   exp_wc;

    prev_wc  = word_count;
    start    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    vectors++;
    if (word_count !== prev_wc) begin
      miscompares++;
      $display("FAIL %s wc_hold: got %0d want %0d", tag, word_count, prev_wc);
    end
    tick();
    start = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      vectors++;
      if ({mem_we, mem_waddr, mem_wdata, in_ready, cpu_stall, boot_done} !==
          {1'b1, ADDR_W'(i), {DATA_W{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL %s clear[%0d]: we=%b addr=%0d data=%h rdy=%b stall=%b done=%b want we=1 addr=%0d data=0 rdy=0 stall=1 done=0",
                 tag, i, mem_we, mem_waddr, mem_wdata, in_ready, cpu_stall, boot_done, i);
      end
      if (i == 0) begin
        vectors++;
        if ({word_count, overflow, checksum} !== {(ADDR_W+1)'(0), 1'b0, {DATA_W{1'b0}}}) begin
          miscompares++;
          $display("FAIL %s clear_status: wc=%0d ovf=%b ck=%h want 0 0 0", tag, word_count, overflow, checksum);
        end
      end
      tick();
    end

    k       = 0;
    sum     = '0;
    done    = 1'b0;
    exp_ovf = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      in_valid = v && (k < img.size());
      if (in_valid) begin
        in_data = img[k];
        in_last = (k == last_idx);
      end else begin
        in_data = $urandom;
        in_last = $urandom_range(0, 1) == 1;
      end
      a = ADDR_W'(LOAD_BASE + k);
      @(negedge clk);
      vectors++;
      if (in_valid) begin
        if ({mem_we, mem_waddr, mem_wdata, in_ready, cpu_stall} !== {1'b1, a, img[k], 1'b1, 1'b1}) begin
          miscompares++;
          $display("FAIL %s load_word[%0d]: we=%b addr=%0d data=%h rdy=%b stall=%b want we=1 addr=%0d data=%h rdy=1 stall=1",
                   tag, k, mem_we, mem_waddr, mem_wdata, in_ready, cpu_stall, a, img[k]);
        end
        sum = sum + img[k];
        if (k == last_idx) begin
          done = 1'b1;
        end else if (a == ADDR_W'(DEPTH - 1)) begin
          done    = 1'b1;
          exp_ovf = 1'b1;
        end
        k++;
      end else begin
        if ({mem_we, in_ready, cpu_stall} !== 3'b011) begin
          miscompares++;
          $display("FAIL %s load_gap: we=%b rdy=%b stall=%b want we=0 rdy=1 stall=1", tag, mem_we, in_ready, cpu_stall);
        end
      end
      tick();
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s load_timeout: accepted %0d words, RUN not reached", tag, k);
    end

`ifdef IMEM_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = '0;
`endif
    exp_wc = (k > DEPTH) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(k);

    // Offer one more word in RUN; it must not be taken.
    in_valid = 1'b1;
    in_data  = $urandom;
    in_last  = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_we, in_ready, cpu_stall, boot_done} !== 4'b0001) begin
      miscompares++;
      $display("FAIL %s run_entry: we=%b rdy=%b stall=%b done=%b want 0 0 0 1", tag, mem_we, in_ready, cpu_stall, boot_done);
    end
    vectors++;
    if ({word_count, overflow, checksum} !== {exp_wc, exp_ovf, exp_ck}) begin
      miscompares++;
      $display("FAIL %s run_status: wc=%0d ovf=%b ck=%h want wc=%0d ovf=%b ck=%h",
               tag, word_count, overflow, checksum, exp_wc, exp_ovf, exp_ck);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({mem_we, in_ready, cpu_stall, boot_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s run_hold: we=%b rdy=%b stall=%b done=%b want 0 0 0 0", tag, mem_we, in_ready, cpu_stall, boot_done);
    end
    vectors++;
    if (word_count !== exp_wc) begin
      miscompares++;
      $display("FAIL %s run_wc_hold: got %0d want %0d", tag, word_count, exp_wc);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({state_ok(), in_ready, mem_we, boot_done, overflow, word_count, checksum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (ADDR_W+1)'(0), {DATA_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_values: stall=%b rdy=%b we=%b done=%b ovf=%b wc=%0d ck=%h want stall=1 others 0",
               cpu_stall, in_ready, mem_we, boot_done, overflow, word_count, checksum);
    end
    tick();
    reset = 1'b0;
    // IDLE ignores the stream port.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      vectors++;
      if ({cpu_stall, in_ready, mem_we, boot_done} !== 4'b1000) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: stall=%b rdy=%b we=%b done=%b want 1 0 0 0", i, cpu_stall, in_ready, mem_we, boot_done);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  function automatic logic state_ok();
    return cpu_stall;
  endfunction

  task automatic test_normal_load();
    img = '{32'h20120055, 32'h20130022, 32'h20150077, 32'h20170088,
            32'h20160010, 32'h20110044, 32'h20140068};
    run_boot(6, 0, "normal");
  endtask

  task automatic test_backpressure();
    img = '{32'h20120055, 32'h20130022, 32'h20150077, 32'h20170088,
            32'h20160010, 32'h20110044, 32'h20140068};
    run_boot(6, 1, "backpressure");
  endtask

  task automatic test_overflow();
    img.delete();
    for (int i = 0; i < DEPTH + 1; i++) img.push_back($urandom);
    run_boot(-1, 0, "overflow");
  endtask

  task automatic test_exact_fit();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    run_boot(DEPTH - 1, 0, "exact_fit");
  endtask

  task automatic test_random_images();
    int len;
    for (int n = 0; n < 4; n++) begin
      len = $urandom_range(1, DEPTH + 4);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back($urandom);
      run_boot((len > DEPTH) ? -1 : len - 1, 2, "random");
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (DEPTH) tick();
    // start during LOAD must not restart the sweep.
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, mem_we, cpu_stall} !== 3'b101) begin
      miscompares++;
      $display("FAIL start_in_load: rdy=%b we=%b stall=%b want rdy=1 we=0 stall=1", in_ready, mem_we, cpu_stall);
    end
    tick();
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, ADDR_W'(LOAD_BASE + j), in_data}) begin
        miscompares++;
        $display("FAIL midload_word[%0d]: we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 j, mem_we, mem_waddr, mem_wdata, LOAD_BASE + j, in_data);
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (word_count !== (ADDR_W+1)'(3)) begin
      miscompares++;
      $display("FAIL midload_wc: got %0d want 3", word_count);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({cpu_stall, in_ready, mem_we, boot_done, overflow, word_count, checksum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (ADDR_W+1)'(0), {DATA_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL async_reset: stall=%b rdy=%b we=%b done=%b ovf=%b wc=%0d ck=%h want stall=1 others 0",
               cpu_stall, in_ready, mem_we, boot_done, overflow, word_count, checksum);
    end
    tick();
    reset = 1'b0;
    tick();
    img = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    run_boot(2, 0, "after_reset");
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    test_reset();
    test_normal_load();
    test_backpressure();
    test_overflow();
    test_exact_fit();
    test_reset_mid_load();
    test_random_images();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
